// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with a 16-byte line refilled
// from a pipelined multi-cycle memory. Hits return the instruction in the
// same cycle; a miss stalls the fetch stage until the whole line is valid.
module instr_cache #(
  parameter int NUM_BLOCKS      = 64,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] pc_addr,
  output logic [15:0] instr,
  output logic        stall,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_data_valid,
  output logic [15:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  missTag_q, missTag_d;
  logic [5:0]  missIndex_q, missIndex_d;
  logic [2:0]  issueCnt_q, issueCnt_d;
  logic [2:0]  rcvCnt_q, rcvCnt_d;
  logic [15:0] missCount_q, missCount_d;

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [5:0]            tagArr [NUM_BLOCKS];
  logic [15:0]           dataArr [NUM_BLOCKS][WORDS_PER_BLOCK];

  logic [5:0] reqTag;
  logic [5:0] reqIndex;
  logic [2:0] reqWord;
  logic       unusedPcBit;
  logic       hit;
  logic       fillWrite;
  logic       fillDone;

  assign reqTag      = pc_addr[15:10];
  assign reqIndex    = pc_addr[9:4];
  assign reqWord     = pc_addr[3:1];
  assign unusedPcBit = pc_addr[0];
  assign hit         = valid_q[reqIndex] && (tagArr[reqIndex] == reqTag);
  assign miss_count  = missCount_q;

  // Miss detection, refill sequencing and memory request generation
  always_comb begin
    state_d     = state_q;
    missTag_d   = missTag_q;
    missIndex_d = missIndex_q;
    issueCnt_d  = issueCnt_q;
    rcvCnt_d    = rcvCnt_q;
    missCount_d = missCount_q;
    stall       = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = 16'h0000;
    fillWrite   = 1'b0;
    fillDone    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          stall       = 1'b1;
          state_d     = FILL;
          missTag_d   = reqTag;
          missIndex_d = reqIndex;
          issueCnt_d  = 3'd0;
          rcvCnt_d    = 3'd0;
          if (missCount_q != 16'hFFFF) begin
            missCount_d = missCount_q + 16'd1;
          end
        end
      end
      FILL: begin
        stall      = 1'b1;
        mem_rd     = 1'b1;
        mem_addr   = {missTag_q, missIndex_q, issueCnt_q, 1'b0};
        issueCnt_d = issueCnt_q + 3'd1;
        if (issueCnt_q == 3'd7) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        stall = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Returned words are accepted only while a refill is outstanding
    if ((state_q == FILL || state_q == DRAIN) && mem_data_valid) begin
      fillWrite = 1'b1;
      rcvCnt_d  = rcvCnt_q + 3'd1;
      if (rcvCnt_q == 3'd7) begin
        fillDone = 1'b1;
        state_d  = IDLE;
      end
    end
  end

  // Hit data path; nothing is presented while the fetch stage is stalled
  always_comb begin
    instr = 16'h0000;
    if (hit && !stall) begin
      instr = dataArr[reqIndex][reqWord];
    end
  end

  // Control state, counters and line valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      missTag_q   <= 6'd0;
      missIndex_q <= 6'd0;
      issueCnt_q  <= 3'd0;
      rcvCnt_q    <= 3'd0;
      missCount_q <= 16'd0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      missTag_q   <= missTag_d;
      missIndex_q <= missIndex_d;
      issueCnt_q  <= issueCnt_d;
      rcvCnt_q    <= rcvCnt_d;
      missCount_q <= missCount_d;
      if (fillDone) begin
        valid_q[missIndex_q] <= 1'b1;
      end
    end
  end

  // Tag and data storage; contents survive reset since valid bits gate them
  always_ff @(posedge clk) begin
    if (fillWrite) begin
      dataArr[missIndex_q][rcvCnt_q] <= mem_data;
    end
    if (fillDone) begin
      tagArr[missIndex_q] <= missTag_q;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: a queued memory model with
// configurable return pacing, a read-address scoreboard and table-driven
// fetch vectors around the multi-cycle miss sequences.
module tb_instr_cache;

  typedef struct {
    logic        req;
    logic [15:0] pc;
    logic        expStall;
    logic [15:0] expInstr;
    logic        chkInstr;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } memReq_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [15:0] pc_addr;
  logic [15:0] instr;
  logic        stall;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_data_valid;
  logic [15:0] miss_count;

  int numChecks = 0;
  int numFails  = 0;
  int cyc = 0;
  int rdPulses = 0;
  int validPulses = 0;
  logic altMode = 1'b0;

  memReq_t     pendQ[$];
  logic [15:0] expAddrQ[$];
  vec_t        expQ[$];
  vec_t        hitVecs[8];
  vec_t        altVecs[8];

  instr_cache dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .pc_addr        (pc_addr),
    .instr          (instr),
    .stall          (stall),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: four-cycle latency, in-order returns, optional every-other-cycle pacing
  always @(negedge clk) begin
    cyc++;
    mem_data_valid = 1'b0;
    mem_data       = 16'h0000;
    if (pendQ.size() > 0 && pendQ[0].due <= cyc && (!altMode || (cyc % 2) == 0)) begin
      mem_data       = memWord(pendQ[0].addr);
      mem_data_valid = 1'b1;
      validPulses++;
      void'(pendQ.pop_front());
    end
    if (mem_rd === 1'b1) begin
      pendQ.push_back('{addr: mem_addr, due: cyc + 4});
    end
  end

  // Read-address scoreboard: every issued read must match the next expected address
  always @(negedge clk) begin
    #2;
    if (mem_rd === 1'b1) begin
      rdPulses++;
      if (expAddrQ.size() == 0) begin
        compareValue("mem_rd unexpected", 32'(mem_rd), 32'd0);
      end else begin
        compareValue("mem_addr", 32'(mem_addr), 32'(expAddrQ.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    req     = v.req;
    pc_addr = v.pc;
    expQ.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    #1;
    e = expQ.pop_front();
    compareValue($sformatf("stall@%h", e.pc), 32'(stall), 32'(e.expStall));
    if (e.chkInstr) begin
      compareValue($sformatf("instr@%h", e.pc), 32'(instr), 32'(e.expInstr));
    end
  endtask

  task automatic pushLineAddrs(input logic [15:0] pc);
    for (int i = 0; i < 8; i++) begin
      expAddrQ.push_back({pc[15:4], 4'b0000} + 16'(2 * i));
    end
  endtask

  // Drives a missing fetch and follows it until stall drops; expCycles < 0 skips the exact length
  task automatic runMiss(input logic [15:0] pc, input int expCycles);
    int cnt;
    @(negedge clk);
    req         = 1'b1;
    pc_addr     = pc;
    rdPulses    = 0;
    validPulses = 0;
    pushLineAddrs(pc);
    #1;
    compareValue($sformatf("miss stall@%h", pc), 32'(stall), 32'd1);
    cnt = 0;
    while (stall === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
      #1;
      if (stall === 1'b1 && cnt > 0 && cnt < 13) begin
        compareValue($sformatf("instr during stall@%h", pc), 32'(instr), 32'd0);
      end
    end
    if (expCycles >= 0) begin
      compareValue($sformatf("stall cycles@%h", pc), 32'(cnt), 32'(expCycles));
    end else begin
      compareValue($sformatf("stall extended@%h", pc), 32'(cnt > 13 && cnt < 200), 32'd1);
      compareValue($sformatf("valid pulses@%h", pc), 32'(validPulses), 32'd8);
    end
    compareValue($sformatf("instr after fill@%h", pc), 32'(instr), 32'(memWord({pc[15:1], 1'b0})));
    compareValue($sformatf("read count@%h", pc), 32'(rdPulses), 32'd8);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rdBefore;
    for (int i = 0; i < 7; i++) begin
      hitVecs[i] = '{req: 1'b1, pc: 16'(2 * i + 2), expStall: 1'b0,
                     expInstr: memWord(16'(2 * i + 2)), chkInstr: 1'b1};
    end
    hitVecs[7] = '{req: 1'b1, pc: 16'h0000, expStall: 1'b0, expInstr: 16'hA5A5, chkInstr: 1'b1};
    for (int i = 0; i < 8; i++) begin
      altVecs[i] = '{req: 1'b1, pc: 16'(16'h0020 + 2 * i), expStall: 1'b0,
                     expInstr: memWord(16'(16'h0020 + 2 * i)), chkInstr: 1'b1};
    end

    rst_n   = 1'b0;
    req     = 1'b0;
    pc_addr = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    compareValue("reset stall req0", 32'(stall), 32'd0);
    compareValue("reset mem_rd", 32'(mem_rd), 32'd0);
    compareValue("reset mem_addr", 32'(mem_addr), 32'd0);
    compareValue("reset miss_count", 32'(miss_count), 32'd0);
    req = 1'b1;
    #1;
    compareValue("reset stall req1", 32'(stall), 32'd1);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] cold miss at 0x0000");
    runMiss(16'h0000, 13);
    compareValue("miss_count after first", 32'(miss_count), 32'd1);

    $display("[TB] sequential hits in line 0");
    rdBefore = rdPulses;
    foreach (hitVecs[i]) begin
      applyStimulus(hitVecs[i]);
      checkOutput();
    end
    compareValue("no reads on hits", 32'(rdPulses - rdBefore), 32'd0);

    $display("[TB] conflict on index 0");
    runMiss(16'h0400, 13);
    runMiss(16'h0000, 13);
    compareValue("miss_count after conflict", 32'(miss_count), 32'd3);

    $display("[TB] reset in the middle of a fill");
    @(negedge clk);
    req      = 1'b1;
    pc_addr  = 16'h0010;
    rdPulses = 0;
    pushLineAddrs(16'h0010);
    #1;
    compareValue("fill 0x0010 stall", 32'(stall), 32'd1);
    repeat (7) @(negedge clk);
    #1;
    req   = 1'b0;
    rst_n = 1'b0;
    #1;
    compareValue("midfill reset stall", 32'(stall), 32'd0);
    compareValue("midfill reset mem_rd", 32'(mem_rd), 32'd0);
    compareValue("midfill reset mem_addr", 32'(mem_addr), 32'd0);
    compareValue("midfill reset miss_count", 32'(miss_count), 32'd0);
    compareValue("reads before reset", 32'(rdPulses), 32'd6);
    @(negedge clk);
    expAddrQ.delete();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    compareValue("post reset idle stall", 32'(stall), 32'd0);
    compareValue("post reset miss_count", 32'(miss_count), 32'd0);
    runMiss(16'h0010, 13);
    compareValue("miss_count after refill", 32'(miss_count), 32'd1);

    $display("[TB] slow memory at 0x0020");
    altMode = 1'b1;
    runMiss(16'h0020, -1);
    altMode = 1'b0;
    foreach (altVecs[i]) begin
      applyStimulus(altVecs[i]);
      checkOutput();
    end
    compareValue("miss_count after slow fill", 32'(miss_count), 32'd2);

    $display("[TB] idle fetch on invalid line");
    applyStimulus('{req: 1'b0, pc: 16'h0300, expStall: 1'b0, expInstr: 16'h0000, chkInstr: 1'b0});
    checkOutput();
    repeat (3) @(negedge clk);
    #1;
    compareValue("req0 mem_rd", 32'(mem_rd), 32'd0);
    compareValue("req0 stall", 32'(stall), 32'd0);
    compareValue("req0 miss_count", 32'(miss_count), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
